crc_engine_n: RTL



---
 rtl/crc_engine_n.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/crc_engine_n.sv
// Runtime-configurable bit-serial CRC engine with valid/ready byte input,
// start/finish framing, bit reflection, final XOR and a registered result.
module crc_engine_n #(
  parameter int WIDTH     = 32,
  parameter int BIT_COUNT = 5,
  parameter int DIN_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 finish,
  input  logic                 in_valid,
  input  logic [DIN_W-1:0]     in_data,
  output logic                 in_ready,
  input  logic [BIT_COUNT-1:0] bitwidth,
  input  logic [WIDTH-1:0]     taps,
  input  logic [WIDTH-1:0]     init_value,
  input  logic [WIDTH-1:0]     xor_out,
  input  logic                 reflect_in,
  input  logic                 reflect_out,
  output logic [WIDTH-1:0]     crc_out,
  output logic                 out_valid,
  output logic                 busy
);

  localparam int CNT_W = (DIN_W > 1) ? $clog2(DIN_W) : 1;
  localparam logic [BIT_COUNT-1:0] TOP_IDX = BIT_COUNT'(WIDTH - 1);
  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(DIN_W - 1);

  typedef enum logic [1:0] {IDLE, ACCEPT, SHIFT, DONE} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]     crc_q;
  logic [DIN_W-1:0]     shift_buf;
  logic [CNT_W-1:0]     bit_cnt;
  logic [BIT_COUNT-1:0] top_q;
  logic [WIDTH-1:0]     taps_q;
  logic [WIDTH-1:0]     xor_q;
  logic                 refin_q;
  logic                 refout_q;
  logic                 finish_pending;

  logic [BIT_COUNT-1:0] top_in;
  logic [WIDTH-1:0]     mask_in;
  logic [WIDTH-1:0]     mask_q;
  logic                 d_bit;
  logic                 fb;
  logic [WIDTH-1:0]     crc_next;
  logic [WIDTH-1:0]     result;
  logic                 last_bit;

  // Index of the top CRC bit: w-1, clamped to the physical register.
  function automatic logic [BIT_COUNT-1:0] eff_top(input logic [BIT_COUNT-1:0] bw);
    return (bw > TOP_IDX) ? TOP_IDX : bw;
  endfunction

  function automatic logic [WIDTH-1:0] low_mask(input logic [BIT_COUNT-1:0] top);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      m[i] = (BIT_COUNT'(i) <= top);
    end
    return m;
  endfunction

  function automatic logic [WIDTH-1:0] bitrev_w(input logic [WIDTH-1:0] v,
                                                input logic [BIT_COUNT-1:0] top);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (BIT_COUNT'(i) <= top) begin
        r[i] = v[top - BIT_COUNT'(i)];
      end
    end
    return r;
  endfunction

  always_comb begin
    top_in   = eff_top(bitwidth);
    mask_in  = low_mask(top_in);
    mask_q   = low_mask(top_q);
    d_bit    = refin_q ? shift_buf[0] : shift_buf[DIN_W-1];
    fb       = crc_q[top_q] ^ d_bit;
    crc_next = ((crc_q << 1) & mask_q) ^ (fb ? taps_q : '0);
    result   = refout_q ? bitrev_w(crc_q, top_q) : crc_q;
    last_bit = (bit_cnt == LAST_BIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = ACCEPT;
    end else begin
      case (state)
        IDLE:   state_next = IDLE;
        ACCEPT: begin
          if (in_valid)    state_next = SHIFT;
          else if (finish) state_next = DONE;
        end
        SHIFT: begin
          if (last_bit) state_next = (finish_pending || finish) ? DONE : ACCEPT;
        end
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  // in_ready is withheld while start is asserted, since start discards the word.
  always_comb begin
    in_ready = (state == ACCEPT) && !start;
    busy     = (state == ACCEPT) || (state == SHIFT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_q          <= '0;
      shift_buf      <= '0;
      bit_cnt        <= '0;
      top_q          <= '0;
      taps_q         <= '0;
      xor_q          <= '0;
      refin_q        <= 1'b0;
      refout_q       <= 1'b0;
      finish_pending <= 1'b0;
      crc_out        <= '0;
      out_valid      <= 1'b0;
    end else if (start) begin
      top_q          <= top_in;
      taps_q         <= taps & mask_in;
      xor_q          <= xor_out & mask_in;
      refin_q        <= reflect_in;
      refout_q       <= reflect_out;
      crc_q          <= init_value & mask_in;
      finish_pending <= 1'b0;
      crc_out        <= '0;
      out_valid      <= 1'b0;
    end else begin
      case (state)
        ACCEPT: begin
          if (in_valid) begin
            shift_buf <= in_data;
            bit_cnt   <= '0;
            if (finish) finish_pending <= 1'b1;
          end
        end
        SHIFT: begin
          crc_q     <= crc_next;
          shift_buf <= refin_q ? (shift_buf >> 1) : (shift_buf << 1);
          bit_cnt   <= bit_cnt + 1'b1;
          if (finish) finish_pending <= 1'b1;
        end
        // Result is registered on the first DONE cycle and then held.
        DONE: begin
          if (!out_valid) begin
            crc_out   <= (result ^ xor_q) & mask_q;
            out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
